// File: rtl/hd44780_stream_ctrl.sv
// hd44780_stream_ctrl
// ---------------------------------------------------------------------------
// HD44780 character-LCD controller for the 4-bit bus. After reset it waits
// for the panel to power up, runs the 4-bit init sequence, then streams
// host bytes (command or data) to the LCD as two nibbles each. The cursor
// is tracked so that, when AUTOWRAP is set, a Set-DDRAM command is inserted
// behind the host's back whenever a data byte runs off the end of a line.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   host byte valid
//   in_rs      host RS: 0 = command, 1 = data
//   in_data    host byte
//   in_ready   block accepts a byte this cycle (transfer = in_valid & in_ready)
//   init_done  init sequence complete; held until reset
//   lcd_rs     LCD RS pin
//   lcd_e      LCD E strobe
//   lcd_d      LCD D7..D4 (lcd_d[3] = D7)
//
// Timing of one nibble: SETUP_CYCLES cycles E low with RS/D driven, then
// E_CYCLES cycles E high, then one hold cycle E low. RS/D only change on the
// first setup cycle, so they are never disturbed while E is high.
// ---------------------------------------------------------------------------
module hd44780_stream_ctrl #(
  parameter int SETUP_CYCLES = 2,
  parameter int E_CYCLES     = 4,
  parameter int WAIT_SHORT   = 2000,
  parameter int WAIT_LONG    = 80000,
  parameter int WAIT_POWERUP = 750000,
  parameter int COLS         = 16,
  parameter int ROWS         = 2,
  parameter int AUTOWRAP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [3:0] lcd_d
);

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT_NIB,
    INIT_BYTE,
    IDLE,
    SEND_HI,
    SEND_LO,
    WAIT,
    WRAP_HI,
    WRAP_LO
  } state_t;

  localparam int          NIB_LEN   = SETUP_CYCLES + E_CYCLES + 1;
  localparam logic [15:0] PH_LAST   = 16'(NIB_LEN - 1);
  localparam logic [15:0] E_START   = 16'(SETUP_CYCLES);
  localparam logic [15:0] E_STOP    = 16'(SETUP_CYCLES + E_CYCLES);
  localparam logic [31:0] PWR_LAST  = 32'(WAIT_POWERUP - 1);
  localparam logic [31:0] SHORT_LEN = 32'(WAIT_SHORT);
  localparam logic [31:0] LONG_LEN  = 32'(WAIT_LONG);
  localparam logic [6:0]  COLS_L    = 7'(COLS);
  localparam logic [7:0]  FUNC_SET  = (ROWS == 1) ? 8'h20 : 8'h28;

  // Step numbering: 0..3 are the single init nibbles, 4..7 the init bytes,
  // 8 means normal streaming. WAIT uses it to decide where to go next.
  localparam logic [3:0]  STEP_RUN  = 4'd8;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] wait_len_q, wait_len_d;
  logic [15:0] phase_q, phase_d;
  logic [3:0]  step_q, step_d;
  logic        half_q, half_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        wrap_pend_q, wrap_pend_d;
  logic [6:0]  col_q, col_d;
  logic        row_q, row_d;
  logic        in_ready_q, in_ready_d;
  logic        init_done_q, init_done_d;
  logic        lcd_e_q, lcd_e_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [3:0]  lcd_d_q, lcd_d_d;

  logic        nib_end;
  logic        accept;
  logic        nib_state;
  logic [6:0]  col_inc;
  logic [7:0]  init_byte;

  assign in_ready  = in_ready_q;
  assign init_done = init_done_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_e     = lcd_e_q;
  assign lcd_d     = lcd_d_q;

  // Next-state logic. Every register has its next value computed here; the
  // LCD pin values are derived from the *next* state and phase so that the
  // registered pins line up exactly with the state they belong to.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_len_d  = wait_len_q;
    phase_d     = phase_q;
    step_d      = step_q;
    half_d      = half_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    wrap_pend_d = wrap_pend_q;
    col_d       = col_q;
    row_d       = row_q;
    init_done_d = init_done_q;
    lcd_e_d     = 1'b0;
    lcd_rs_d    = lcd_rs_q;
    lcd_d_d     = lcd_d_q;
    init_byte   = 8'h00;

    nib_end = (phase_q == PH_LAST);
    accept  = in_valid & in_ready_q;
    col_inc = col_q + 7'd1;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d = INIT_NIB;
          cnt_d   = 32'd0;
          phase_d = 16'd0;
          step_d  = 4'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      INIT_NIB: begin
        if (nib_end) begin
          state_d    = WAIT;
          cnt_d      = 32'd0;
          // The first two 0x3 nibbles need the long settle time.
          wait_len_d = (step_q < 4'd2) ? LONG_LEN : SHORT_LEN;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end

      INIT_BYTE: begin
        if (nib_end) begin
          if (!half_q) begin
            half_d  = 1'b1;
            phase_d = 16'd0;
          end else begin
            half_d     = 1'b0;
            state_d    = WAIT;
            cnt_d      = 32'd0;
            // Step 6 is the clear-display byte.
            wait_len_d = (step_q == 4'd6) ? LONG_LEN : SHORT_LEN;
          end
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end

      IDLE: begin
        if (accept) begin
          byte_d  = in_data;
          rs_d    = in_rs;
          state_d = SEND_HI;
          phase_d = 16'd0;
          // Cursor bookkeeping happens at latch time so a wrap can be
          // scheduled before the byte is even on the bus.
          if (in_rs) begin
            if ((AUTOWRAP != 0) && (col_inc >= COLS_L)) begin
              col_d       = 7'd0;
              row_d       = (ROWS == 2) ? ~row_q : 1'b0;
              wrap_pend_d = 1'b1;
            end else begin
              col_d = col_inc;
            end
          end else if ((in_data == 8'h01) || (in_data == 8'h02)) begin
            col_d = 7'd0;
            row_d = 1'b0;
          end else if (in_data[7]) begin
            row_d = (ROWS == 1) ? 1'b0 : in_data[6];
            col_d = {1'b0, in_data[5:0]};
          end
        end
      end

      SEND_HI: begin
        if (nib_end) begin
          state_d = SEND_LO;
          phase_d = 16'd0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end

      SEND_LO: begin
        if (nib_end) begin
          state_d    = WAIT;
          cnt_d      = 32'd0;
          wait_len_d = (!rs_q && ((byte_q == 8'h01) || (byte_q == 8'h02)))
                       ? LONG_LEN : SHORT_LEN;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end

      WRAP_HI: begin
        if (nib_end) begin
          state_d = WRAP_LO;
          phase_d = 16'd0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end

      WRAP_LO: begin
        if (nib_end) begin
          state_d    = WAIT;
          cnt_d      = 32'd0;
          wait_len_d = SHORT_LEN;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end

      WAIT: begin
        if (cnt_q == (wait_len_q - 32'd1)) begin
          phase_d = 16'd0;
          if (step_q < STEP_RUN) begin
            step_d = step_q + 4'd1;
            half_d = 1'b0;
            if (step_q < 4'd3) begin
              state_d = INIT_NIB;
            end else if (step_q < 4'd7) begin
              state_d = INIT_BYTE;
            end else begin
              state_d     = IDLE;
              init_done_d = 1'b1;
              col_d       = 7'd0;
              row_d       = 1'b0;
            end
          end else if (wrap_pend_q) begin
            // Row was already advanced when the overflowing byte was latched.
            wrap_pend_d = 1'b0;
            byte_d      = row_q ? 8'hC0 : 8'h80;
            state_d     = WRAP_HI;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = PWR_WAIT;
        cnt_d   = 32'd0;
      end
    endcase

    // in_ready rises one cycle after the block settles in IDLE, so the
    // accept cycle is followed by a fixed 1 + 2N + wait cycles of not-ready.
    in_ready_d = (state_q == IDLE) && (state_d == IDLE);

    case (step_d)
      4'd4:    init_byte = FUNC_SET;
      4'd5:    init_byte = 8'h0C;
      4'd6:    init_byte = 8'h01;
      4'd7:    init_byte = 8'h06;
      default: init_byte = 8'h00;
    endcase

    nib_state = (state_d == INIT_NIB) || (state_d == INIT_BYTE) ||
                (state_d == SEND_HI)  || (state_d == SEND_LO)   ||
                (state_d == WRAP_HI)  || (state_d == WRAP_LO);

    // Pin values are constant over a whole nibble; they only take a new
    // value on phase 0, which is always an E-low cycle.
    if (nib_state) begin
      lcd_e_d = (phase_d >= E_START) && (phase_d < E_STOP);
      case (state_d)
        INIT_NIB: begin
          lcd_rs_d = 1'b0;
          lcd_d_d  = (step_d == 4'd3) ? 4'h2 : 4'h3;
        end
        INIT_BYTE: begin
          lcd_rs_d = 1'b0;
          lcd_d_d  = half_d ? init_byte[3:0] : init_byte[7:4];
        end
        SEND_HI: begin
          lcd_rs_d = rs_d;
          lcd_d_d  = byte_d[7:4];
        end
        SEND_LO: begin
          lcd_rs_d = rs_d;
          lcd_d_d  = byte_d[3:0];
        end
        WRAP_HI: begin
          lcd_rs_d = 1'b0;
          lcd_d_d  = byte_d[7:4];
        end
        default: begin
          lcd_rs_d = 1'b0;
          lcd_d_d  = byte_d[3:0];
        end
      endcase
    end
  end

  // State and registered outputs. Reset is asynchronous so E drops the
  // moment rst rises, even in the middle of a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= 32'd0;
      wait_len_q  <= 32'd0;
      phase_q     <= 16'd0;
      step_q      <= 4'd0;
      half_q      <= 1'b0;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      wrap_pend_q <= 1'b0;
      col_q       <= 7'd0;
      row_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_d_q     <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_len_q  <= wait_len_d;
      phase_q     <= phase_d;
      step_q      <= step_d;
      half_q      <= half_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      wrap_pend_q <= wrap_pend_d;
      col_q       <= col_d;
      row_q       <= row_d;
      in_ready_q  <= in_ready_d;
      init_done_q <= init_done_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_d_q     <= lcd_d_d;
    end
  end

endmodule

// File: doc/hd44780_stream_ctrl.md
# hd44780_stream_ctrl

Parametrised HD44780 character-LCD controller for the 4-bit bus, the next generation of the namebadge LCD driver. It performs the power-up init sequence, then accepts bytes (command or data) from a host over a valid/ready handshake. Each byte is split into two nibbles with programmable E-strobe and settle timing. It tracks the cursor and optionally inserts line-wrap commands. It sits between any message/effect generator and the LCD pins (RS, E, D4-D7).

## Interface
Parameters:
- `SETUP_CYCLES`, default 2: cycles RS/D are stable with E low before E rises (≥1).
- `E_CYCLES`, default 4: E high width in cycles (≥1).
- `WAIT_SHORT`, default 2000: settle cycles after a normal byte or init nibble.
- `WAIT_LONG`, default 80000: settle cycles after clear/home (0x01/0x02) and after init nibbles 1-2.
- `WAIT_POWERUP`, default 750000: cycles from reset release to first init nibble.
- `COLS`, default 16: visible columns (2..64).
- `ROWS`, default 2: 1 or 2 only.
- `AUTOWRAP`, default 1: 1 = insert Set-DDRAM on column overflow.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: host byte valid.
- `in_rs` in 1: 0 = command, 1 = data.
- `in_data` in 8: byte to send.
- `in_ready` out 1: block can accept a byte this cycle.
- `init_done` out 1: high once init sequence completes; stays high until reset.
- `lcd_rs` out 1: LCD RS.
- `lcd_e` out 1: LCD E strobe.
- `lcd_d` out 4: LCD D7..D4 (`lcd_d[3]`=D7).

## Operation
- States: PWR_WAIT → INIT_NIB → INIT_BYTE → IDLE → SEND_HI → SEND_LO → WAIT → (WRAP_HI → WRAP_LO → WAIT) → IDLE.
- PWR_WAIT: count WAIT_POWERUP cycles.
- INIT_NIB: send single nibbles with RS=0:
  - 0x3, then wait WAIT_LONG.
  - 0x3, then wait WAIT_LONG.
  - 0x3, then wait WAIT_SHORT.
  - 0x2, then wait WAIT_SHORT.
- INIT_BYTE: full bytes with RS=0: 0x28 (0x20 if ROWS=1), 0x0C, 0x01 (long wait), 0x06. Then `init_done`=1, col=row=0, go to IDLE.
- IDLE: `in_ready`=1. A transfer occurs on `in_valid & in_ready`. The byte and RS are latched, and `in_ready` is 0 from the next cycle until the block returns to IDLE.
- Byte send: high nibble (`in_data[7:4]`), then low nibble, RS constant for both. Then WAIT for WAIT_LONG if RS=0 and data is 0x01 or 0x02, otherwise WAIT_SHORT.
- Cursor tracking, applied when the byte is latched:
  - Data byte: col+1.
  - 0x01/0x02: col=row=0.
  - Command with bit7=1: row=data[6] (forced 0 if ROWS=1), col=data[5:0].
  - Other commands: no change.
- Wrap: if AUTOWRAP=1 and a data byte leaves col ≥ COLS, the block sets col=0 and row=(row+1) mod ROWS. After that byte's WAIT it sends command 0x80|(row?0x40:0x00) plus WAIT_SHORT before returning to IDLE.
- The host never sees wrap bytes. `in_ready` stays 0 throughout.
- Bytes offered during init are not accepted (`in_ready`=0).

## Timing
- Nibble = SETUP_CYCLES cycles with E=0 and RS/D driven, then E_CYCLES cycles with E=1, then 1 hold cycle with E=0 and RS/D unchanged. Length N = SETUP_CYCLES+E_CYCLES+1.
- Byte = 2N cycles, then wait count.
- Accept cycle to `in_ready` high again = 1 + 2N + wait. With wrap, add 2N + WAIT_SHORT.
- `lcd_d`/`lcd_rs` change only when E=0. Exactly one E pulse per nibble.
- Reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_d`=0, `in_ready`=0, `init_done`=0, col=row=0, state PWR_WAIT.
- Reset asserted mid-nibble forces E low asynchronously. Full init is repeated after release.
- Outside nibble windows, `lcd_d` holds its last value and E=0.

## Test plan
- Init (small params: SETUP=1, E=2, SHORT=5, LONG=10, POWERUP=20): release reset. Required:
  - First E rises at cycle 20+1.
  - 12 E pulses with nibbles 3,3,3,2,2,8,0,C,0,1,0,6, all RS=0.
  - `init_done` and `in_ready` high after the final wait.
- Data write: after init, offer 0x41 RS=1. Required: nibbles 4 then 1 with RS=1; `in_ready` low for exactly 1+2·4+5 = 14 cycles.
- Clear: offer command 0x01. Required: nibbles 0,1 with RS=0; `in_ready` low for 1+8+10 = 19 cycles; col/row reset.
- Autowrap (COLS=16, ROWS=2):
  - 16 data bytes, then an extra command 0xC0 with no host request.
  - 16 more bytes, then 0x80.
  - With AUTOWRAP=0: no extra pulses.
- Handshake: hold `in_valid` high continuously with changing data. Required: each byte accepted once, only on cycles with `in_ready`=1; no duplicates or drops.
- Reset mid-operation: assert `rst` while E=1. Required: `lcd_e`=0 in the same cycle, all outputs at reset values, init sequence restarts from PWR_WAIT.
